rv64_iter_divider: RTL and testbench

- Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and the W variants.
- Responder side of the execute stage's divide handshake: the execute stage pulses div_valid with operands, then waits for a one-cycle out_valid pulse.
- Returns quotient and remainder together; the execute stage selects and latches the one it needs.

---
 rtl/rv64_iter_divider_pkg.sv | 12 +
 rtl/rv64_iter_divider.sv | 86 ++++++++
 tb/tb_rv64_iter_divider.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/rv64_iter_divider_pkg.sv
// rv64_iter_divider_pkg: FSM encodings, iteration counts and sign helper shared by the divide path
package rv64_iter_divider_pkg;
    localparam int DIV_XLEN = 64;
    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_CALC = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;
    localparam logic [6:0] DIV_CNT_64 = 7'd64;
    localparam logic [6:0] DIV_CNT_32 = 7'd32;
    function automatic logic [DIV_XLEN-1:0] div_sign_fix(input logic [DIV_XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction
endpackage

// File: rtl/rv64_iter_divider.sv
// rv64_iter_divider: radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W forms
module rv64_iter_divider
    import rv64_iter_divider_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_valid,
    input  logic            flush,
    input  logic            div_signed,
    input  logic            divw,
    input  logic [XLEN-1:0] div_op1,
    input  logic [XLEN-1:0] div_op2,
    output logic            div_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int HW = XLEN / 2;
    logic [1:0] state;
    logic [6:0] cnt;
    logic [XLEN-1:0] quo, rem, dvs, quo_keep, rem_keep;
    logic sign_q, sign_r, w_r;
    logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, wmin, q_fix, r_fix, q_res, r_res;
    logic [XLEN:0] rem_sh;
    logic ge, div_zero, ovf, special, accept;
    always_comb begin
        a_ext = divw ? (div_signed ? {{HW{div_op1[HW-1]}}, div_op1[HW-1:0]} : {{HW{1'b0}}, div_op1[HW-1:0]}) : div_op1;
        b_ext = divw ? (div_signed ? {{HW{div_op2[HW-1]}}, div_op2[HW-1:0]} : {{HW{1'b0}}, div_op2[HW-1:0]}) : div_op2;
        a_abs = div_sign_fix(a_ext, div_signed & a_ext[XLEN-1]);
        b_abs = div_sign_fix(b_ext, div_signed & b_ext[XLEN-1]);
        wmin = divw ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = b_ext == '0;
        ovf = div_signed & (a_ext == wmin) & (&b_ext);
        special = div_zero | ovf;
        accept = div_valid & div_ready & ~flush;
        // rem needs one extra bit after the shift; the subtraction then fits back in XLEN
        rem_sh = {rem, quo[XLEN-1]};
        ge = rem_sh >= {1'b0, dvs};
        q_fix = div_sign_fix(quo, sign_q);
        r_fix = div_sign_fix(rem, sign_r);
        q_res = w_r ? {{HW{q_fix[HW-1]}}, q_fix[HW-1:0]} : q_fix;
        r_res = w_r ? {{HW{r_fix[HW-1]}}, r_fix[HW-1:0]} : r_fix;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
            cnt <= '0;
            quo <= '0;
            rem <= '0;
            dvs <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            w_r <= 1'b0;
            quo_keep <= '0;
            rem_keep <= '0;
        end else if (flush) begin
            state <= DIV_IDLE;
            cnt <= '0;
        end else if (accept) begin
            // special cases preload their final magnitudes so DONE treats every op alike
            state <= special ? DIV_DONE : DIV_CALC;
            cnt <= special ? 7'd0 : (divw ? DIV_CNT_32 : DIV_CNT_64);
            w_r <= divw;
            dvs <= b_abs;
            sign_q <= div_signed & ~special & (a_ext[XLEN-1] ^ b_ext[XLEN-1]);
            sign_r <= div_signed & ~special & a_ext[XLEN-1];
            quo <= div_zero ? '1 : ovf ? a_ext : divw ? a_abs << HW : a_abs;
            rem <= div_zero ? a_ext : '0;
        end else if (state == DIV_CALC) begin
            quo <= {quo[XLEN-2:0], ge};
            rem <= ge ? rem_sh[XLEN-1:0] - dvs : rem_sh[XLEN-1:0];
            cnt <= cnt - 7'd1;
            state <= cnt == 7'd1 ? DIV_DONE : DIV_CALC;
        end else if (state == DIV_DONE) begin
            quo_keep <= q_res;
            rem_keep <= r_res;
            state <= DIV_IDLE;
        end
    end
    assign div_ready = state == DIV_IDLE;
    assign out_valid = state == DIV_DONE;
    assign quotient = out_valid ? q_res : quo_keep;
    assign remainder = out_valid ? r_res : rem_keep;
endmodule

// File: tb/tb_rv64_iter_divider.sv
// tb_rv64_iter_divider: directed and random checks of the divider against an arithmetic reference
module tb_rv64_iter_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic div_valid = 1'b0;
    logic flush = 1'b0;
    logic div_signed = 1'b0;
    logic divw = 1'b0;
    logic [63:0] div_op1 = '0;
    logic [63:0] div_op2 = '0;
    logic div_ready, out_valid;
    logic [63:0] quotient, remainder;
    int total = 0;
    int bad = 0;
    logic [63:0] last_q = '0;
    logic [63:0] last_r = '0;

    rv64_iter_divider dut (
        .clk(clk), .rst(rst), .div_valid(div_valid), .flush(flush),
        .div_signed(div_signed), .divw(divw), .div_op1(div_op1), .div_op2(div_op2),
        .div_ready(div_ready), .out_valid(out_valid), .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_div(input logic s, input logic w, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] q, output logic [63:0] r, output int lat);
        logic [31:0] a32, b32, q32, r32;
        a32 = a[31:0];
        b32 = b[31:0];
        q32 = '0;
        r32 = '0;
        if (w) begin
            lat = 33;
            if (b32 == 0) begin
                q32 = '1; r32 = a32; lat = 1;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = '0; lat = 1;
            end else if (s) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            lat = 65;
            if (b == 0) begin
                q = '1; r = a; lat = 1;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a; r = '0; lat = 1;
            end else if (s) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endfunction

    task automatic start_op(input logic s, input logic w, input logic [63:0] a, input logic [63:0] b);
        int i;
        i = 0;
        while (!div_ready && i < 200) begin
            tick();
            i++;
        end
        if (!div_ready) chk("ready_wait", 64'(div_ready), 64'd1);
        div_valid = 1'b1; div_signed = s; divw = w; div_op1 = a; div_op2 = b;
        tick();
        // scramble inputs to prove operands were captured at accept
        div_valid = 1'b0;
        div_signed = 1'($urandom);
        divw = 1'($urandom);
        div_op1 = {$urandom, $urandom};
        div_op2 = {$urandom, $urandom};
    endtask

    task automatic finish_op(input string tag, input int exp_lat, input logic [63:0] eq, input logic [63:0] er);
        int n;
        logic busy_ok;
        n = 1;
        busy_ok = 1'b1;
        while (!out_valid && n < 100) begin
            busy_ok &= !div_ready && quotient === last_q && remainder === last_r;
            tick();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        tick();
        chk({tag, "_pulse"}, 64'(out_valid), 64'd0);
        chk({tag, "_hold"}, quotient ^ remainder, eq ^ er);
        last_q = eq;
        last_r = er;
    endtask

    task automatic run_op(input string tag, input logic s, input logic w, input logic [63:0] a, input logic [63:0] b,
                          input int exp_lat, input logic [63:0] eq, input logic [63:0] er);
        start_op(s, w, a, b);
        finish_op(tag, exp_lat, eq, er);
    endtask

    initial begin
        logic quiet;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", 64'(div_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_q", quotient, 64'd0);
        chk("rst_r", remainder, 64'd0);

        run_op("divu", 1'b0, 1'b0, 64'd100, 64'd7, 65, 64'd14, 64'd2);
        run_op("div_neg", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("div_negb", 1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1);
        run_op("dz", 1'b0, 1'b0, 64'h1234, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234);
        run_op("dzw", 1'b1, 1'b1, 64'hAAAA_AAAA_8000_0000, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
        run_op("ovf", 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h8000_0000_0000_0000, 64'd0);
        run_op("ovfw", 1'b1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 1, 64'hFFFF_FFFF_8000_0000, 64'd0);
        run_op("divuw", 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 33, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0);

        // flush on the same cycle as a request drops the request
        div_valid = 1'b1; flush = 1'b1; div_op1 = 64'd9; div_op2 = 64'd3;
        tick();
        div_valid = 1'b0; flush = 1'b0;
        chk("flush_prio_ready", 64'(div_ready), 64'd1);

        start_op(1'b0, 1'b0, 64'd5000, 64'd3);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_ready", 64'(div_ready), 64'd1);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_q", quotient, last_q);
        chk("flush_r", remainder, last_r);
        run_op("after_flush", 1'b0, 1'b0, 64'd100, 64'd7, 65, 64'd14, 64'd2);

        start_op(1'b1, 1'b0, 64'd12345, 64'd11);
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_ready", 64'(div_ready), 64'd1);
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_q", quotient, 64'd0);
        chk("mrst_r", remainder, 64'd0);
        quiet = 1'b1;
        repeat (70) begin
            quiet &= !out_valid;
            tick();
        end
        chk("mrst_nopulse", 64'(quiet), 64'd1);
        last_q = '0;
        last_r = '0;

        for (int k = 0; k < 40; k++) begin
            logic s, w;
            logic [63:0] a, b, eq, er;
            int lat;
            s = 1'($urandom);
            w = 1'($urandom);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = 64'($urandom_range(1, 15));
                2: begin
                    b = '1;
                    a = w ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
                end
                3: b = b >> $urandom_range(0, 62);
                default: ;
            endcase
            ref_div(s, w, a, b, eq, er, lat);
            run_op("rnd", s, w, a, b, lat, eq, er);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
